// File: rtl/jtag_seq_master.sv
// Command-driven JTAG scan sequencer: one IR/DR scan per command, Idle to Idle.
// Define JTAG_SEQ_TLR_CMD_EN to add the cmd_tlr Test-Logic-Reset command.
module jtag_seq_master #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               tclk,
  input  logic               trst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_ir,
`ifdef JTAG_SEQ_TLR_CMD_EN
  input  logic               cmd_tlr,
`endif
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy
);

  localparam int CNT_W = (MAX_LEN > 8) ? $clog2(MAX_LEN) : 3;

  typedef enum logic [3:0] {
    INIT,
    IDLE,
    SEL_DR,
    SEL_IR,
    CAPTURE,
    SHIFT,
    EXIT1,
    UPDATE,
    DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   len_m1;
  logic [CNT_W-1:0]   len_m1_c;
  logic [MAX_LEN-1:0] sreg;
  logic               ir_q;
  logic               cap_wait;
  logic               accept;
`ifdef JTAG_SEQ_TLR_CMD_EN
  logic               tlr_q;
`endif

  assign accept  = cmd_valid & cmd_ready;
  assign cnt_nxt = cnt + CNT_W'(1);

  // Last bit index: zero length shifts one bit, long requests clamp
  always_comb begin
    len_m1_c = '0;
    if (cmd_len > LEN_W'(MAX_LEN))
      len_m1_c = CNT_W'(MAX_LEN - 1);
    else if (cmd_len != '0)
      len_m1_c = CNT_W'(cmd_len - LEN_W'(1));
  end

  always_ff @(posedge tclk or posedge trst) begin
    if (trst) begin
      state     <= INIT;
      cnt       <= '0;
      len_m1    <= '0;
      sreg      <= '0;
      ir_q      <= 1'b0;
      cap_wait  <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
`ifdef JTAG_SEQ_TLR_CMD_EN
      tlr_q     <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      tdi       <= 1'b0;
      unique case (state)
        // Five tms=1 cycles then one tms=0 lands the TAP in Idle
        INIT: begin
          if (cnt == CNT_W'(5)) begin
            tms       <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
`ifdef JTAG_SEQ_TLR_CMD_EN
            if (tlr_q) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              busy      <= 1'b0;
            end
`endif
          end else begin
            cnt <= cnt_nxt;
            tms <= (cnt != CNT_W'(4));
          end
        end
        IDLE, DONE: begin
          tms   <= 1'b0;
          state <= IDLE;
          if (accept) begin
            ir_q      <= cmd_ir;
            sreg      <= cmd_data;
            len_m1    <= len_m1_c;
            cnt       <= '0;
            cap_wait  <= 1'b1;
            rsp_data  <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            tms       <= 1'b1;
            state     <= SEL_DR;
`ifdef JTAG_SEQ_TLR_CMD_EN
            tlr_q     <= cmd_tlr;
            if (cmd_tlr)
              state <= INIT;
`endif
          end
        end
        SEL_DR: begin
          tms   <= ir_q;
          state <= ir_q ? SEL_IR : CAPTURE;
        end
        SEL_IR: begin
          tms   <= 1'b0;
          state <= CAPTURE;
        end
        // Two tms=0 cycles: into Capture, then into Shift
        CAPTURE: begin
          cap_wait <= 1'b0;
          tms      <= 1'b0;
          if (!cap_wait) begin
            tms   <= (len_m1 == '0);
            tdi   <= sreg[0];
            sreg  <= sreg >> 1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          rsp_data[cnt] <= tdo;
          if (cnt == len_m1) begin
            tms   <= 1'b1;
            state <= EXIT1;
          end else begin
            cnt  <= cnt_nxt;
            tms  <= (cnt_nxt == len_m1);
            tdi  <= sreg[0];
            sreg <= sreg >> 1;
          end
        end
        EXIT1: begin
          tms   <= 1'b0;
          state <= UPDATE;
        end
        UPDATE: begin
          tms       <= 1'b0;
          rsp_valid <= 1'b1;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= DONE;
        end
        default: begin
          tms   <= 1'b1;
          cnt   <= '0;
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_seq_master.sv
// Directed bench for jtag_seq_master; per-cycle tms/tdi/strobe vectors
// are compared against hand-computed constants (bit k-1 = cycle k).
module tb_jtag_seq_master;

  logic        tclk = 1'b0;
  logic        trst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ir = 1'b0;
  logic [5:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        tdo = 1'b0;
  logic        cmd_ready;
  logic        tms;
  logic        tdi;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;
`ifdef JTAG_SEQ_TLR_CMD_EN
  logic        cmd_tlr = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [63:0] tms_v, tdi_v, rv_v, busy_v, rdy_v;
  logic [31:0] rsp_first, rsp_last;

  jtag_seq_master #(.MAX_LEN(32), .LEN_W(6)) dut (
    .tclk      (tclk),
    .trst      (trst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ir    (cmd_ir),
`ifdef JTAG_SEQ_TLR_CMD_EN
    .cmd_tlr   (cmd_tlr),
`endif
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 tclk = ~tclk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic ir,
                       input logic [5:0] len,
                       input logic [31:0] data);
    cmd_ir    = ir;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
  endtask

  // Sample ncyc cycles after an accept; poke re-raises cmd_valid while busy
  task automatic run(input string tag,
                     input int ncyc,
                     input logic [63:0] tdo_v,
                     input int poke,
                     input logic [63:0] exp_tms,
                     input logic [63:0] exp_tdi,
                     input int exp_done,
                     input logic [31:0] exp_rsp);
    logic [63:0] m, e_rv, e_busy;
    tms_v = '0; tdi_v = '0; rv_v = '0;
    busy_v = '0; rdy_v = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge tclk);
      tms_v[k-1]  = tms;
      tdi_v[k-1]  = tdi;
      rv_v[k-1]   = rsp_valid;
      busy_v[k-1] = busy;
      rdy_v[k-1]  = cmd_ready;
      if (k == 1) rsp_first = rsp_data;
      rsp_last = rsp_data;
      cmd_valid = (k == poke);
      if (k == poke) begin
        cmd_ir   = ~cmd_ir;
        cmd_data = ~cmd_data;
      end
      tdo = tdo_v[k-1];
    end
    m      = (64'd1 << ncyc) - 64'd1;
    e_rv   = 64'd1 << (exp_done - 1);
    e_busy = e_rv - 64'd1;
    check({tag, " tms"}, tms_v, exp_tms);
    check({tag, " tdi"}, tdi_v, exp_tdi);
    check({tag, " rsp_valid"}, rv_v, e_rv);
    check({tag, " busy"}, busy_v, e_busy);
    check({tag, " cmd_ready"}, rdy_v, ~e_busy & m);
    check({tag, " rsp_clr"}, 64'(rsp_first), 64'd0);
    check({tag, " rsp_data"}, 64'(rsp_last), 64'(exp_rsp));
  endtask

  // Assert trst now, check reset values, release and watch INIT
  task automatic do_reset(input string tag);
    trst = 1'b1;
    cmd_valid = 1'b0;
    #1;
    check({tag, " rst outs"},
          64'({tms, tdi, cmd_ready, rsp_valid, busy}), 64'b10000);
    check({tag, " rst rsp"}, 64'(rsp_data), 64'd0);
    repeat (2) @(negedge tclk);
    trst = 1'b0;
    tms_v = '0; rdy_v = '0; rv_v = '0;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(negedge tclk);
      tms_v[k-1] = tms;
      rdy_v[k-1] = cmd_ready;
      rv_v[k-1]  = rsp_valid;
    end
    check({tag, " init tms"}, tms_v, 64'h1F);
    check({tag, " init ready"}, rdy_v, 64'h40);
    check({tag, " init rsp_valid"}, rv_v, 64'h0);
  endtask

  initial begin
    #2;
    do_reset("reset");

    issue(1'b1, 6'd4, 32'h0000_000F);
    run("ir4", 12, 64'h0, 0, 64'h183, 64'hF0, 11, 32'h0);

    issue(1'b0, 6'd8, 32'h0000_00A5);
    run("dr8", 15, '1, 0, 64'hC01, 64'h528, 14, 32'h0000_00FF);

    issue(1'b0, 6'd8, 32'h0000_003C);
    run("dr8_busy_poke", 15, 64'h169A, 5,
        64'hC01, 64'h1E0, 14, 32'h0000_00D3);

    issue(1'b0, 6'd0, 32'hFFFF_FFFF);
    run("len0", 8, '1, 0, 64'h19, 64'h8, 7, 32'h1);

    issue(1'b0, 6'd40, 32'hDEAD_BEEF);
    run("len40", 38, '1, 0,
        (64'd1 | (64'd1 << 34) | (64'd1 << 35)),
        (64'h0000_0000_DEAD_BEEF << 3), 38, 32'hFFFF_FFFF);

    // Accepted in the DONE cycle of the previous scan
    issue(1'b1, 6'd4, 32'h0000_0005);
    run("b2b_ir4", 12, 64'hA0, 0, 64'h183, 64'h50, 11, 32'hA);

    issue(1'b0, 6'd8, 32'h0000_00A5);
    tdo = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge tclk);
      if (k == 1) cmd_valid = 1'b0;
    end
    check("abort pre tdi", 64'(tdi), 64'd1);
    check("abort pre busy", 64'(busy), 64'd1);
    do_reset("abort");

    issue(1'b0, 6'd8, 32'h0000_00A5);
    run("post_abort", 15, '1, 0, 64'hC01, 64'h528, 14, 32'h0000_00FF);

`ifdef JTAG_SEQ_TLR_CMD_EN
    cmd_tlr = 1'b1;
    issue(1'b1, 6'd4, 32'h0000_000F);
    run("tlr", 8, '1, 0, 64'h1F, 64'h0, 7, 32'h0);
    cmd_tlr = 1'b0;
    issue(1'b0, 6'd8, 32'h0000_00A5);
    run("post_tlr", 15, '1, 0, 64'hC01, 64'h528, 14, 32'h0000_00FF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
